// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit.
// Defines the next-PC source select encoding.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_MARMUX = 2'b01,
        PC_BUS    = 2'b10,
        PC_RET    = 2'b11
    } pcmux_t;

endpackage

// File: rtl/return_stack.sv
// Circular LIFO of return addresses; ptr addresses the current top entry.
// Ports: clk, reset; push/pop/replace commands, wdata in; top, empty,
//   full, overflow/underflow single-cycle strobes out.
module return_stack #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);
    import pc_pkg::*;

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;

    assign ptr_inc   = ptr + PTR_W'(1);
    assign ptr_dec   = ptr - PTR_W'(1);
    assign top       = mem[ptr];
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(RAS_DEPTH));
    assign overflow  = push & full;
    assign underflow = (pop | replace) & empty;

    // Entries need no reset: nothing reads them while the stack is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_inc] <= wdata;
        end else if (replace) begin
            mem[ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            // When full the oldest slot is overwritten and count saturates.
            ptr <= ptr_inc;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (!empty) begin
                ptr   <= ptr_dec;
                count <= count - CNT_W'(1);
            end
        end else if (replace) begin
            if (empty) begin
                count <= CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program counter with next-PC mux and a hardware return-address stack.
// Ports: Clk, Reset, LD_PC, PCMUX, CALL, CLR_FLAGS, MARMUX, datapath in;
//   PC, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF out.
module pc_unit_ras #(
    parameter int               WIDTH        = 16,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               INC          = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LD_PC,
    input  logic [1:0]       PCMUX,
    input  logic             CALL,
    input  logic             CLR_FLAGS,
    input  logic [WIDTH-1:0] MARMUX,
    input  logic [WIDTH-1:0] datapath,
    output logic [WIDTH-1:0] PC,
    output logic             RAS_EMPTY,
    output logic             RAS_FULL,
    output logic             RAS_OVF,
    output logic             RAS_UNF
);
    import pc_pkg::*;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    pcmux_t           sel;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ras_top;
    logic             is_ret;
    logic             push;
    logic             pop;
    logic             replace;
    logic             ovf_ev;
    logic             unf_ev;

    assign sel     = pcmux_t'(PCMUX);
    assign pc_inc  = PC + INC_W;
    assign is_ret  = (sel == PC_RET);
    assign push    = LD_PC & CALL & ~is_ret;
    assign pop     = LD_PC & is_ret & ~CALL;
    // CALL together with RET is a tail call: swap the top in place.
    assign replace = LD_PC & is_ret & CALL;

    return_stack #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (Clk),
        .reset     (Reset),
        .push      (push),
        .pop       (pop),
        .replace   (replace),
        .wdata     (pc_inc),
        .top       (ras_top),
        .empty     (RAS_EMPTY),
        .full      (RAS_FULL),
        .overflow  (ovf_ev),
        .underflow (unf_ev)
    );

    always_comb begin
        pc_next = PC;
        if (LD_PC) begin
            case (sel)
                PC_INC:    pc_next = pc_inc;
                PC_MARMUX: pc_next = MARMUX;
                PC_BUS:    pc_next = datapath;
                PC_RET:    pc_next = RAS_EMPTY ? pc_inc : ras_top;
                default:   pc_next = PC;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC      <= RESET_VECTOR;
            RAS_OVF <= 1'b0;
            RAS_UNF <= 1'b0;
        end else begin
            PC      <= pc_next;
            // A new event in the clearing cycle keeps the flag set.
            RAS_OVF <= ovf_ev | (RAS_OVF & ~CLR_FLAGS);
            RAS_UNF <= unf_ev | (RAS_UNF & ~CLR_FLAGS);
        end
    end

endmodule
